// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that packs four bytes, first byte most significant, into one 32-bit word.
// Completed words go out as one-cycle writes to the PC RX FIFO.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 435,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_uart_rx,
  input  logic        i_fifo_full,
  output logic [31:0] o_word_data,
  output logic        o_word_valid,
  output logic        o_rx_active,
  output logic [1:0]  o_byte_count,
  output logic        o_framing_error,
  output logic        o_overflow,
  output logic        o_timeout
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          sync1;
  logic          sync2;
  logic          line;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [23:0]   asm_word;
  logic [TW-1:0] to_cnt;
  logic          clk_done;
  logic          byte_ok;
  logic          frame_err;
  logic          to_fire;

  assign line        = sync2;
  assign clk_done    = (clk_cnt == BIT_END);
  assign o_rx_active = (state != IDLE);

  // Two-flop synchroniser; idle-high line resets to 1
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
    end
  end

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next state and byte/error/timeout strobes
  always_comb begin
    state_n   = state;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    to_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!line) begin
          state_n = START;
        end else if (o_byte_count != 2'd0 && to_cnt == TO_END) begin
          to_fire = 1'b1;
        end
      end
      START: begin
        if (clk_cnt == BIT_MID) state_n = line ? IDLE : DATA;
      end
      DATA: begin
        if (clk_done && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (clk_done) begin
          if (line) begin
            byte_ok = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timing, bit index and data shift register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        START: begin
          clk_cnt <= (clk_cnt == BIT_MID) ? '0 : clk_cnt + C_ONE;
          bit_idx <= '0;
        end
        DATA: begin
          clk_cnt <= clk_done ? '0 : clk_cnt + C_ONE;
          if (clk_done) begin
            shreg   <= {line, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: clk_cnt <= clk_done ? '0 : clk_cnt + C_ONE;
        default: clk_cnt <= '0;
      endcase
    end
  end

  // Inter-byte idle timer, live only while a partial word is pending
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      to_cnt <= '0;
    end else if (state == IDLE && line &&
                 o_byte_count != 2'd0 && !to_fire) begin
      to_cnt <= to_cnt + T_ONE;
    end else begin
      to_cnt <= '0;
    end
  end

  // Word assembly and the one-cycle result pulses
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      asm_word        <= '0;
      o_byte_count    <= '0;
      o_word_data     <= '0;
      o_word_valid    <= 1'b0;
      o_overflow      <= 1'b0;
      o_framing_error <= 1'b0;
      o_timeout       <= 1'b0;
    end else begin
      o_word_valid    <= 1'b0;
      o_overflow      <= 1'b0;
      o_framing_error <= 1'b0;
      o_timeout       <= 1'b0;
      if (byte_ok) begin
        asm_word     <= {asm_word[15:0], shreg};
        o_byte_count <= o_byte_count + 2'd1;
        if (o_byte_count == 2'd3) begin
          o_word_data  <= {asm_word, shreg};
          o_word_valid <= !i_fifo_full;
          o_overflow   <= i_fifo_full;
        end
      end else if (frame_err) begin
        asm_word        <= '0;
        o_byte_count    <= '0;
        o_framing_error <= 1'b1;
      end else if (to_fire) begin
        asm_word     <= '0;
        o_byte_count <= '0;
        o_timeout    <= 1'b1;
      end
    end
  end

endmodule
